// File: rtl/program_loader.sv
// rtl/program_loader.sv - framed byte-stream boot loader writing 16-bit words into instruction memory
// Define CHECKSUM_EN to require a trailing 16-bit XOR checksum (count ^ all data words) per frame.
module program_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_en_write,
    output logic [ADDR_W-1:0] im_address,
    output logic [15:0]       im_data_in,
    output logic              core_reset,
    output logic              core_start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [3:0] {
        IDLE, CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE,
        CSUM_HI, CSUM_LO, RELEASE, DONE, ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t state, state_nxt;
    logic [7:0]      hi_byte;
    logic [15:0]     word_cnt;
    logic [15:0]     rx_word;
    logic [ADDR_W:0] words_loaded_inc;
    logic            last_word;
    logic            xfer;
`ifdef CHECKSUM_EN
    logic [15:0]     csum;
`endif

    assign rx_word          = {hi_byte, rx_data};
    assign xfer             = rx_valid & rx_ready;
    assign words_loaded_inc = words_loaded + 1'b1;
    assign last_word        = (16'(words_loaded_inc) == word_cnt);

    // Status is a pure function of state, so DONE raises core_start and drops core_reset together.
    assign busy       = (state != IDLE) && (state != DONE) && (state != ERR);
    assign done       = (state == DONE);
    assign error      = (state == ERR);
    assign core_reset = (state != DONE);
    assign core_start = (state == DONE);

    always_comb begin
        state_nxt   = state;
        rx_ready    = 1'b0;
        im_en_write = 1'b0;
        case (state)
            IDLE, DONE, ERR: if (load_req) state_nxt = CNT_HI;
            CNT_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = CNT_LO;
            end
            CNT_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_word == 16'd0 || {1'b0, rx_word} > MAX_N) state_nxt = ERR;
                    else                                             state_nxt = DAT_HI;
                end
            end
            DAT_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = DAT_LO;
            end
            DAT_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = WRITE;
            end
            WRITE: begin
                im_en_write = 1'b1;
`ifdef CHECKSUM_EN
                state_nxt = last_word ? CSUM_HI : DAT_HI;
`else
                state_nxt = last_word ? RELEASE : DAT_HI;
`endif
            end
`ifdef CHECKSUM_EN
            CSUM_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = CSUM_LO;
            end
            CSUM_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = (rx_word == csum) ? RELEASE : ERR;
            end
`endif
            RELEASE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            hi_byte      <= '0;
            word_cnt     <= '0;
            im_address   <= '0;
            im_data_in   <= '0;
            words_loaded <= '0;
`ifdef CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (load_req && !busy) begin
                words_loaded <= '0;
                im_address   <= '0;
            end
            if (xfer && (state == CNT_HI || state == DAT_HI || state == CSUM_HI))
                hi_byte <= rx_data;
            if (xfer && state == CNT_LO) begin
                word_cnt <= rx_word;
`ifdef CHECKSUM_EN
                csum     <= rx_word;
`endif
            end
            if (xfer && state == DAT_LO) begin
                im_data_in <= rx_word;
`ifdef CHECKSUM_EN
                csum       <= csum ^ rx_word;
`endif
            end
            // Address holds on the final word so a full-size image never wraps back to 0.
            if (state == WRITE) begin
                words_loaded <= words_loaded_inc;
                if (!last_word) im_address <= im_address + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader
module tb_program_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_req;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_en_write;
    logic [ADDR_W-1:0] im_address;
    logic [15:0]       im_data_in;
    logic              core_reset;
    logic              core_start;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W+15:0] exp_q[$];
    logic [ADDR_W+15:0] mon_exp;
    logic [15:0]        fw[0:1023];

    always #5 clk = ~clk;

    program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .reset(reset), .load_req(load_req),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .im_en_write(im_en_write), .im_address(im_address), .im_data_in(im_data_in),
        .core_reset(core_reset), .core_start(core_start), .busy(busy),
        .done(done), .error(error), .words_loaded(words_loaded)
    );

    always @(negedge clk) begin
        if (im_en_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL im_write_unexpected: got addr %0d data %h, required no write", im_address, im_data_in);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({im_address, im_data_in} !== mon_exp) begin
                    errors++;
                    $display("FAIL im_write: got addr %0d data %h, required addr %0d data %h",
                             im_address, im_data_in, mon_exp[ADDR_W+15:16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic pulse_load;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t = 0;
        if (gaps && $urandom_range(0, 1) == 1) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout: byte %h never accepted, required acceptance", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps, input bit bad);
        logic [15:0] nw;
        logic [15:0] cs;
        nw = n[15:0];
        cs = nw;
        send_byte(nw[15:8], gaps);
        send_byte(nw[7:0], gaps);
        for (int i = 0; i < n; i++) begin
            cs = cs ^ fw[i];
            send_byte(fw[i][15:8], gaps);
            exp_q.push_back({ADDR_W'(i), fw[i]});
            send_byte(fw[i][7:0], gaps);
        end
        cs = cs ^ {15'd0, bad};
`ifdef CHECKSUM_EN
        send_byte(cs[15:8], gaps);
        send_byte(cs[7:0], gaps);
`endif
    endtask

    task automatic wait_end;
        int t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++; errors++;
            $display("FAIL end_timeout: done %b error %b, required done or error", done, error);
        end
    endtask

    task automatic check_drained(input string name);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes_missing: %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_vals(input string name);
        logic [ADDR_W+33:0] got;
        logic [ADDR_W+33:0] req;
        got = {rx_ready, im_en_write, core_start, busy, done, error, core_reset,
               im_address, im_data_in, words_loaded};
        req = {7'b0000001, {(ADDR_W + 27){1'b0}}};
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: outputs %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        pulse_load;
        checks++;
        if (busy !== 1'b1 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: busy %b core_reset %b, required 1 1", busy, core_reset);
        end
        exp_q.push_back({ADDR_W'(0), 16'h4004});
        exp_q.push_back({ADDR_W'(1), 16'h7000});
        send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h40, 0); send_byte(8'h04, 0);
        send_byte(8'h70, 0); send_byte(8'h00, 0);
        checks++;
        if (im_en_write !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: im_en_write %b, required 1 one cycle after low byte", im_en_write);
        end
`ifdef CHECKSUM_EN
        send_byte(8'h30, 0); send_byte(8'h06, 0);
`else
        @(negedge clk);
`endif
        checks++;
        if (core_reset !== 1'b1 || core_start !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: core_reset %b core_start %b done %b, required 1 0 0",
                     core_reset, core_start, done);
        end
        @(negedge clk);
        checks++;
        if ({core_reset, core_start, done, busy, error} !== 5'b01100 || words_loaded !== 11'd2) begin
            errors++;
            $display("FAIL basic_done: rst %b start %b done %b busy %b err %b words %0d, required 0 1 1 0 0 2",
                     core_reset, core_start, done, busy, error, words_loaded);
        end
        check_drained("basic");
    endtask

    task automatic test_backpressure;
        pulse_load;
        fw[0] = 16'h4004; fw[1] = 16'h7000;
        send_frame(2, 1, 0);
        wait_end;
        checks++;
        if (done !== 1'b1 || words_loaded !== 11'd2) begin
            errors++;
            $display("FAIL bp_done: done %b words %0d, required 1 2", done, words_loaded);
        end
        check_drained("bp");
        pulse_load;
        for (int i = 0; i < 5; i++) fw[i] = 16'($urandom);
        send_frame(5, 1, 0);
        wait_end;
        checks++;
        if (done !== 1'b1 || words_loaded !== 11'd5 || core_start !== 1'b1) begin
            errors++;
            $display("FAIL bp5_done: done %b words %0d start %b, required 1 5 1", done, words_loaded, core_start);
        end
        check_drained("bp5");
    endtask

    task automatic test_bad_count;
        pulse_load;
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        checks++;
        if ({error, done, busy, core_reset, core_start} !== 5'b10010 || words_loaded !== 11'd0) begin
            errors++;
            $display("FAIL zero_count: err %b done %b busy %b rst %b start %b words %0d, required 1 0 0 1 0 0",
                     error, done, busy, core_reset, core_start, words_loaded);
        end
        repeat (3) @(negedge clk);
        pulse_load;
        send_byte(8'h04, 0); send_byte(8'h01, 0);
        checks++;
        if (error !== 1'b1 || core_reset !== 1'b1 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL over_count: err %b rst %b rx_ready %b, required 1 1 0", error, core_reset, rx_ready);
        end
        check_drained("bad_count");
    endtask

    task automatic test_reset_mid_load;
        pulse_load;
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h40, 0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_reset_values");
        reset = 1'b0;
        @(negedge clk);
        pulse_load;
        fw[0] = 16'h4004; fw[1] = 16'h7000;
        send_frame(2, 0, 0);
        wait_end;
        checks++;
        if (done !== 1'b1 || words_loaded !== 11'd2 || im_address !== 10'd1) begin
            errors++;
            $display("FAIL mid_reset_reload: done %b words %0d addr %0d, required 1 2 1", done, words_loaded, im_address);
        end
        check_drained("mid_reset");
    endtask

    task automatic test_load_req_busy;
        pulse_load;
        exp_q.push_back({ADDR_W'(0), 16'h4004});
        exp_q.push_back({ADDR_W'(1), 16'h7000});
        send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h40, 0);
        pulse_load;
        send_byte(8'h04, 0); send_byte(8'h70, 0); send_byte(8'h00, 0);
`ifdef CHECKSUM_EN
        send_byte(8'h30, 0); send_byte(8'h06, 0);
`endif
        wait_end;
        checks++;
        if (done !== 1'b1 || words_loaded !== 11'd2) begin
            errors++;
            $display("FAIL busy_ignore: done %b words %0d, required 1 2", done, words_loaded);
        end
        check_drained("busy_ignore");
        pulse_load;
        checks++;
        if ({core_reset, core_start, busy, done} !== 4'b1010 || words_loaded !== 11'd0) begin
            errors++;
            $display("FAIL restart: rst %b start %b busy %b done %b words %0d, required 1 0 1 0 0",
                     core_reset, core_start, busy, done, words_loaded);
        end
        fw[0] = 16'hBEEF;
        send_frame(1, 0, 0);
        wait_end;
        check_drained("restart");
    endtask

    task automatic test_max_words;
        pulse_load;
        for (int i = 0; i < MAX_WORDS; i++) fw[i] = 16'(i * 3) ^ 16'h5A5A;
        send_frame(MAX_WORDS, 0, 0);
        wait_end;
        checks++;
        if (done !== 1'b1 || words_loaded !== 11'd1024 || im_address !== 10'd1023) begin
            errors++;
            $display("FAIL max_words: done %b words %0d addr %0d, required 1 1024 1023", done, words_loaded, im_address);
        end
        check_drained("max_words");
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum;
        pulse_load;
        fw[0] = 16'h4004; fw[1] = 16'h7000;
        send_frame(2, 0, 0);
        wait_end;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL csum_good: done %b, required 1", done);
        end
        check_drained("csum_good");
        pulse_load;
        send_frame(2, 0, 1);
        wait_end;
        checks++;
        if (error !== 1'b1 || core_start !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL csum_bad: err %b start %b rst %b, required 1 0 1", error, core_start, core_reset);
        end
        check_drained("csum_bad");
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_bad_count;
        test_reset_mid_load;
        test_load_req_busy;
        test_max_words;
`ifdef CHECKSUM_EN
        test_checksum;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
